uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter.
REQ-002 Parameter DATA_W, default 10, frame payload width presented to the transmitter.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles to wait for transmitter done per frame.
REQ-004 Parameter GAP_CYC, default 2, idle cycles with tx_en low between frames.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low.
REQ-007 req_valid  in  NUM_REQ  per-requester frame available.
REQ-008 req_data  in  NUM_REQ*DATA_W  per-requester frames, requester i at bits [i*DATA_W +: DATA_W].
REQ-009 req_ready  out  NUM_REQ  one-hot accept pulse; a frame transfers when valid and ready are both high.
REQ-010 tx_en  out  1  enable to the transmitter.
REQ-011 tx_data  out  DATA_W  frame to the transmitter, stable while tx_en is high.
REQ-012 tx_done  in  1  transmitter frame-complete pulse.
REQ-013 grant_id  out  clog2(NUM_REQ)  index of the requester currently owning the transmitter.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 timeout_err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-016 FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
REQ-017 IDLE: with any req_valid high, the arbiter selects one requester round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-018 In the selection cycle, the arbiter drives req_ready of the winner only, captures its req_data into tx_data, updates grant_id and last_grant, and moves to LAUNCH.
REQ-019 A requester whose valid drops before selection is not granted; there is no ready without valid.
REQ-020 LAUNCH: tx_en goes high for the first time, the watchdog clears to 0, and the FSM moves to WAIT_DONE; latency from accept to tx_en high is 1 cycle.
REQ-021 WAIT_DONE: tx_en stays high and tx_data is held; tx_done high causes a move to GAP.
REQ-022 WAIT_DONE: the watchdog increments each cycle; when it reaches TIMEOUT-1 without tx_done, timeout_err pulses and the FSM moves to GAP.
REQ-023 If tx_done and watchdog expiry coincide, done wins and no timeout_err is raised.
REQ-024 tx_done outside WAIT_DONE is ignored.
REQ-025 GAP: tx_en is low for exactly GAP_CYC cycles, counted by the gap counter, then the FSM returns to IDLE.
REQ-026 No new grant is issued before the GAP exit; the maximum grant rate is one per frame.
REQ-027 Under continuous request from all requesters, grants rotate 0,1,2,3,0…; no requester waits more than NUM_REQ-1 frames.
REQ-028 Counters are sized to hold TIMEOUT-1 and GAP_CYC without wrap; the watchdog saturates and never wraps.

Reset
REQ-029 While rst is low at a clock edge: FSM enters IDLE; tx_en, req_ready, timeout_err and busy are 0; tx_data and grant_id are 0; last_grant is NUM_REQ-1, so requester 0 wins first.
REQ-030 Reset during WAIT_DONE abandons the frame immediately: tx_en is low on the next cycle and no req_ready or timeout_err is issued.
REQ-031 No output is X after the first reset edge.

Structure
REQ-032 A shared package holds the FSM state enum, the default parameter constants and the TIMEOUT/GAP counter width functions.
REQ-033 One sub-module, rr_arbiter_nreq, implements combinational round-robin selection from (req_valid, last_grant) and returns a one-hot grant plus index; it has no other logic.
REQ-034 The FSM, counters and capture registers live in uart_tx_arbiter.

Verification
REQ-035 Single request: req_valid=0001, data=0x2A5, tx_done 12 cycles after tx_en -> req_ready=0001 for 1 cycle; tx_en high 1 cycle later with tx_data=0x2A5; tx_en low for 2 cycles; busy=0 afterward.
REQ-036 All four requesters valid continuously -> grant_id sequence 0,1,2,3,0 and one req_ready pulse per frame.
REQ-037 tx_done never asserted, TIMEOUT=64 -> timeout_err pulses once, 63 cycles after entering WAIT_DONE; the next grant goes to the next requester.
REQ-038 tx_done in the same cycle as watchdog expiry -> timeout_err stays 0 and the FSM moves to GAP.
REQ-039 rst low mid-WAIT_DONE -> tx_en=0, busy=0, grant_id=0 next cycle; after release, requester 0 is granted first.
REQ-040 req_valid=0100 pulsed for 1 cycle while busy -> no grant is issued for requester 2.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 10;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_GAP_CYC = 2;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } state_t;

  function automatic int cnt_w(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int timeout_cnt_w(input int timeout);
    return cnt_w(timeout - 1);
  endfunction

  function automatic int gap_cnt_w(input int gap_cyc);
    return cnt_w(gap_cyc);
  endfunction

endpackage

// File: rtl/rr_arbiter_nreq.sv
// Combinational round-robin pick: searches from last_grant+1 upward with wrap.
module rr_arbiter_nreq
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [idx_w(NUM_REQ)-1:0]   last_grant,
  output logic [NUM_REQ-1:0]          grant,
  output logic [idx_w(NUM_REQ)-1:0]   grant_idx
);

  localparam int IDX_W = idx_w(NUM_REQ);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(last_grant) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters: round-robin grant,
// frame launch, done/watchdog wait and an inter-frame idle gap.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_en,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_done,
  output logic [idx_w(NUM_REQ)-1:0]   grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int WD_W  = timeout_cnt_w(TIMEOUT);
  localparam int GAP_W = gap_cnt_w(GAP_CYC);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_t             state, state_nxt;
  logic [WD_W-1:0]    wd, wd_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [IDX_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] sel_grant;
  logic [IDX_W-1:0]   sel_idx;
  logic               accept;
  logic               expire;

  rr_arbiter_nreq #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (sel_grant),
    .grant_idx  (sel_idx)
  );

  always_comb begin
    state_nxt = state;
    wd_nxt    = wd;
    gap_nxt   = gap_cnt;
    accept    = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept    = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_nxt    = '0;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        // done takes priority over a coincident watchdog expiry
        if (tx_done) begin
          gap_nxt   = '0;
          state_nxt = GAP;
        end else if (wd == WD_MAX) begin
          expire    = 1'b1;
          gap_nxt   = '0;
          state_nxt = GAP;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_nxt   = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are gated so nothing is accepted or flagged during reset.
  always_comb begin
    req_ready   = (accept && rst) ? sel_grant : '0;
    timeout_err = expire && rst;
    tx_en       = (state == LAUNCH) || (state == WAIT_DONE);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      wd         <= '0;
      gap_cnt    <= '0;
      tx_data    <= '0;
      grant_id   <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      state   <= state_nxt;
      wd      <= wd_nxt;
      gap_cnt <= gap_nxt;
      if (accept) begin
        tx_data    <= req_data[sel_idx*DATA_W +: DATA_W];
        grant_id   <= sel_idx;
        last_grant <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with default parameters.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [39:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_en;
  logic [9:0]  tx_data;
  logic        tx_done = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] D0 = 10'h2A5;
  localparam logic [9:0] D1 = 10'h111;
  localparam logic [9:0] D2 = 10'h0F3;
  localparam logic [9:0] D3 = 10'h3C8;
  logic [9:0] dtab [4];

  assign req_data = {D3, D2, D1, D0};

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .DATA_W (10),
    .TIMEOUT(64),
    .GAP_CYC(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; tx_done = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = 4'hF; tx_done = 1'b1;
    cyc();
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b exp 0", tx_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b exp 0", timeout_err); end
    checks++; if (tx_data !== 10'h000) begin errors++; $display("FAIL reset_tx_data: got %h exp 000", tx_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d exp 0", grant_id); end
    req_valid = '0; tx_done = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b exp 0001", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b exp 0", busy); end
    cyc();
    req_valid = '0; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_pulse: got %b exp 0000", req_ready); end
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL single_launch_tx_en: got %b exp 1", tx_en); end
    checks++; if (tx_data !== D0) begin errors++; $display("FAIL single_tx_data: got %h exp %h", tx_data, D0); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant_id: got %0d exp 0", grant_id); end
    for (int i = 1; i < 12; i++) begin
      cyc();
      checks++; if ({tx_en, tx_data} !== {1'b1, D0}) begin errors++; $display("FAIL single_hold[%0d]: got en=%b data=%h exp en=1 data=%h", i, tx_en, tx_data, D0); end
    end
    cyc();
    tx_done = 1'b1; #1;
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL single_done_tx_en: got %b exp 1", tx_en); end
    cyc();
    tx_done = 1'b0;
    checks++; if ({tx_en, busy} !== 2'b01) begin errors++; $display("FAIL single_gap1: got en/busy=%b exp 01", {tx_en, busy}); end
    cyc();
    checks++; if ({tx_en, busy} !== 2'b01) begin errors++; $display("FAIL single_gap2: got en/busy=%b exp 01", {tx_en, busy}); end
    cyc();
    checks++; if ({tx_en, busy} !== 2'b00) begin errors++; $display("FAIL single_after_gap: got en/busy=%b exp 00", {tx_en, busy}); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      exp_ready = 4'(1 << e);
      #1;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready[%0d]: got %b exp %b", k, req_ready, exp_ready); end
      cyc();
      checks++; if (grant_id !== 2'(e)) begin errors++; $display("FAIL rr_grant_id[%0d]: got %0d exp %0d", k, grant_id, e); end
      checks++; if (tx_data !== dtab[e]) begin errors++; $display("FAIL rr_tx_data[%0d]: got %h exp %h", k, tx_data, dtab[e]); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_launch_ready[%0d]: got %b exp 0000", k, req_ready); end
      cyc();
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_gap1_ready[%0d]: got %b exp 0000", k, req_ready); end
      cyc();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_gap2_ready[%0d]: got %b exp 0000", k, req_ready); end
      cyc();
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    do_reset();
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    cyc();
    for (int i = 0; i < 63; i++) begin
      if (timeout_err !== 1'b0 || tx_en !== 1'b1) early++;
      cyc();
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL timeout_early: got %0d bad cycles exp 0", early); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b exp 1", timeout_err); end
    req_valid = 4'b0011;
    cyc();
    checks++; if ({timeout_err, tx_en, busy} !== 3'b001) begin errors++; $display("FAIL timeout_gap: got err/en/busy=%b exp 001", {timeout_err, tx_en, busy}); end
    cyc();
    cyc(); #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL timeout_next_ready: got %b exp 0010", req_ready); end
    cyc();
    req_valid = '0;
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL timeout_next_grant: got %0d exp 1", grant_id); end
    cyc();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_done_wins();
    do_reset();
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    cyc();
    for (int i = 0; i < 63; i++) cyc();
    tx_done = 1'b1; #1;
    checks++; if ({timeout_err, tx_en} !== 2'b01) begin errors++; $display("FAIL done_wins_err: got err/en=%b exp 01", {timeout_err, tx_en}); end
    cyc();
    tx_done = 1'b0;
    checks++; if ({timeout_err, tx_en, busy} !== 3'b001) begin errors++; $display("FAIL done_wins_gap: got err/en/busy=%b exp 001", {timeout_err, tx_en, busy}); end
    cyc(); cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_wins_idle: got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rst_mid_first_ready: got %b exp 0100", req_ready); end
    cyc();
    req_valid = '0;
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL rst_mid_grant2: got %0d exp 2", grant_id); end
    cyc(); cyc(); cyc();
    rst = 1'b0; req_valid = 4'hF;
    cyc();
    checks++; if ({tx_en, busy, timeout_err} !== 3'b000) begin errors++; $display("FAIL rst_mid_outputs: got en/busy/err=%b exp 000", {tx_en, busy, timeout_err}); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_mid_grant_id: got %0d exp 0", grant_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready: got %b exp 0000", req_ready); end
    rst = 1'b1; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_release_ready: got %b exp 0001", req_ready); end
    cyc();
    req_valid = '0;
    checks++; if ({grant_id, tx_data} !== {2'd0, D0}) begin errors++; $display("FAIL rst_mid_release_grant: got id=%0d data=%h exp id=0 data=%h", grant_id, tx_data, D0); end
    cyc();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_ignored();
    do_reset();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    checks++; if ({busy, tx_en, timeout_err} !== 3'b000) begin errors++; $display("FAIL idle_done_ignored: got busy/en/err=%b exp 000", {busy, tx_en, timeout_err}); end
    req_valid = 4'b0001;
    cyc();
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL busy_pulse_ready: got %b exp 0000", req_ready); end
    cyc();
    req_valid = '0;
    cyc();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({busy, req_ready} !== 5'b0) begin errors++; $display("FAIL busy_pulse_no_grant[%0d]: got busy=%b ready=%b exp 0/0000", i, busy, req_ready); end
      cyc();
    end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL busy_pulse_grant_id: got %0d exp 0", grant_id); end
  endtask

  initial begin
    dtab[0] = D0; dtab[1] = D1; dtab[2] = D2; dtab[3] = D3;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_wins();
    test_reset_mid_wait();
    test_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
